// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with a ready handshake.
// Shift-add multiply or restoring divide on operand magnitudes, one step per cycle.
module muldiv_unit #(
    parameter logic [7:0] OP_MUL    = 8'h40,
    parameter logic [7:0] OP_MULH   = 8'h41,
    parameter logic [7:0] OP_MULHSU = 8'h42,
    parameter logic [7:0] OP_MULHU  = 8'h43,
    parameter logic [7:0] OP_DIV    = 8'h44,
    parameter logic [7:0] OP_DIVU   = 8'h45,
    parameter logic [7:0] OP_REM    = 8'h46,
    parameter logic [7:0] OP_REMU   = 8'h47
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  inst_i,
    input  logic [31:0] reg1_data_i,
    input  logic [31:0] reg2_data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        exception_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state;
    logic [2:0]  op;
    logic        neg;
    logic [31:0] m;
    logic [63:0] p;
    logic [5:0]  cnt;
    logic        is_md, is_div, s1, s2, div_zero, ovf;
    logic [31:0] mag1, mag2, special, dv, res;
    logic [32:0] sum;
    logic [33:0] diff;
    logic [63:0] p_nxt, prod;
    always_comb begin
        is_md    = inst_i == OP_MUL || inst_i == OP_MULH || inst_i == OP_MULHSU || inst_i == OP_MULHU ||
                   inst_i == OP_DIV || inst_i == OP_DIVU || inst_i == OP_REM || inst_i == OP_REMU;
        is_div   = inst_i == OP_DIV || inst_i == OP_DIVU || inst_i == OP_REM || inst_i == OP_REMU;
        s1       = reg1_data_i[31] & (inst_i == OP_MUL || inst_i == OP_MULH || inst_i == OP_MULHSU ||
                                      inst_i == OP_DIV || inst_i == OP_REM);
        s2       = reg2_data_i[31] & (inst_i == OP_MUL || inst_i == OP_MULH ||
                                      inst_i == OP_DIV || inst_i == OP_REM);
        mag1     = s1 ? -reg1_data_i : reg1_data_i;
        mag2     = s2 ? -reg2_data_i : reg2_data_i;
        div_zero = is_div && reg2_data_i == 32'd0;
        ovf      = (inst_i == OP_DIV || inst_i == OP_REM) && reg1_data_i == 32'h8000_0000 && reg2_data_i == 32'hFFFF_FFFF;
        special  = div_zero ? ((inst_i == OP_REM || inst_i == OP_REMU) ? reg1_data_i : 32'hFFFF_FFFF)
                            : (inst_i == OP_REM ? 32'd0 : 32'h8000_0000);
        // op[2] selects divide; divide p is {remainder, quotient}, multiply p is {partial high, multiplier}
        sum      = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
        diff     = {1'b0, p[63:31]} - {2'b00, m};
        p_nxt    = op[2] ? (diff[33] ? {p[62:0], 1'b0} : {diff[31:0], p[30:0], 1'b1}) : {sum, p[31:1]};
        prod     = neg ? -p_nxt : p_nxt;
        dv       = op[1] ? p_nxt[63:32] : p_nxt[31:0];
        res      = op[2] ? (neg ? -dv : dv) : (op[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
        ready_o  = state == IDLE ? !is_md : state == DONE;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            op          <= 3'd0;
            neg         <= 1'b0;
            m           <= 32'd0;
            p           <= 64'd0;
            cnt         <= 6'd0;
            data_o      <= 32'd0;
            exception_o <= 1'b0;
        end else if (state == IDLE) begin
            if (is_md) begin
                op  <= inst_i[2:0];
                neg <= (inst_i == OP_REM) ? s1 : s1 ^ s2;
                m   <= is_div ? mag2 : mag1;
                p   <= {32'd0, is_div ? mag1 : mag2};
                cnt <= 6'd32;
                if (div_zero || ovf) begin
                    data_o      <= special;
                    exception_o <= div_zero;
                    state       <= DONE;
                end else begin
                    state <= BUSY;
                end
            end
        end else if (state == BUSY) begin
            p   <= p_nxt;
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
                data_o <= res;
                state  <= DONE;
            end
        end else begin
            exception_o <= 1'b0;
            state       <= IDLE;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed checks of muldiv_unit results, latency and flags,
// plus hand-written reset sequences.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  inst = 8'h00;
    logic [31:0] r1 = 32'd0, r2 = 32'd0;
    logic [31:0] data;
    logic        ready, exc;
    int          cmp = 0, err = 0;

    typedef struct {
        logic [7:0]  inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;
    localparam int NV = 16;
    vec_t v [NV];

    muldiv_unit dut (
        .clk_i(clk), .rst_i(rst), .inst_i(inst), .reg1_data_i(r1), .reg2_data_i(r2),
        .data_o(data), .ready_o(ready), .exception_o(exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        logic [31:0] held;
        v[0]  = '{8'h40, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33};
        v[1]  = '{8'h41, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33};
        v[2]  = '{8'h42, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33};
        v[3]  = '{8'h43, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
        v[4]  = '{8'h41, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 33};
        v[5]  = '{8'h44, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0, 33};
        v[6]  = '{8'h46, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b0, 33};
        v[7]  = '{8'h45, 32'd100,        32'd7,         32'd14,        1'b0, 33};
        v[8]  = '{8'h47, 32'd100,        32'd7,         32'd2,         1'b0, 33};
        v[9]  = '{8'h44, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b1, 1};
        v[10] = '{8'h47, 32'h0000_1234,  32'd0,         32'h0000_1234, 1'b1, 1};
        v[11] = '{8'h44, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1};
        v[12] = '{8'h46, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
        v[13] = '{8'h45, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33};
        v[14] = '{8'h44, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0, 33};
        v[15] = '{8'h46, 32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0, 33};

        #12;
        check("rst_data", data, 32'd0);
        check("rst_exc", {31'd0, exc}, 32'd0);
        check("rst_ready_idle", {31'd0, ready}, 32'd1);
        inst = 8'h44;
        #1 check("rst_ready_op", {31'd0, ready}, 32'd0);
        inst = 8'h00;
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            inst = v[i].inst; r1 = v[i].a; r2 = v[i].b;
            #1 check($sformatf("v%0d_ready_low", i), {31'd0, ready}, 32'd0);
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
                if (n == 1) begin r1 = $urandom; r2 = $urandom; end
            end while (!ready && n < 100);
            check($sformatf("v%0d_latency", i), 32'(n), 32'(v[i].lat));
            check($sformatf("v%0d_data", i), data, v[i].res);
            check($sformatf("v%0d_exc", i), {31'd0, exc}, {31'd0, v[i].exc});
            inst = 8'h00;
            @(posedge clk); #1;
            check($sformatf("v%0d_idle_ready", i), {31'd0, ready}, 32'd1);
            check($sformatf("v%0d_exc_clear", i), {31'd0, exc}, 32'd0);
            check($sformatf("v%0d_data_hold", i), data, v[i].res);
        end

        // reset mid-operation: start a MUL, then pull reset at BUSY cycle 10
        @(negedge clk);
        inst = 8'h40; r1 = 32'd5; r2 = 32'd6;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_data", data, 32'd0);
        check("midrst_ready_op", {31'd0, ready}, 32'd0);
        inst = 8'h00;
        #1 check("midrst_ready_idle", {31'd0, ready}, 32'd1);
        @(negedge clk) rst = 1'b1;
        held = data;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, ready}, 32'd1);
        check("post_rst_data", data, 32'd0);
        check("post_rst_exc", {31'd0, exc}, 32'd0);
        check("post_rst_hold", data, held);

        // unit resumes normally after reset
        @(negedge clk);
        inst = 8'h40; r1 = 32'd5; r2 = 32'd6;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 100);
        check("resume_latency", 32'(n), 32'd33);
        check("resume_data", data, 32'd30);
        inst = 8'h00;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
